// File: rtl/strb_axis_pkg.sv
// strb_axis_pkg: shared sizing helpers and status flag type for strb_axis_fifo.
`default_nettype none

package strb_axis_pkg;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic overflow;
    logic full;
    logic empty;
  } flags_t;

endpackage

`default_nettype wire

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: wrap-bit read/write pointers, full/empty/level and push/pop qualification.
`default_nettype none

module fifo_ptr_ctrl
  import strb_axis_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       sreset,
  input  logic                       strb,
  input  logic                       tready,
  output logic                       push,
  output logic                       pop,
  output logic [$clog2(DEPTH)-1:0]   wr_addr,
  output logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int ADDR_W = addr_w(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign pop  = !empty && tready;
  assign push = strb && (!full || pop);

  // Modulo-2*DEPTH difference yields 0..DEPTH directly.
  assign level   = wr_ptr - rd_ptr;
  assign wr_addr = wr_ptr[ADDR_W-1:0];
  assign rd_addr = rd_ptr[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (sreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/strb_axis_fifo.sv
// strb_axis_fifo: strobed vector updates into a first-word fall-through FIFO with an AXI stream output.
// Define STRB_AXIS_FIFO_DROP_CNT_EN to add the saturating drop_cnt output.
`default_nettype none

module strb_axis_fifo
  import strb_axis_pkg::*;
#(
  parameter int WIDTH          = 2,
  parameter int DEPTH          = 4,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      sreset,
  input  logic                      i_strb,
  input  logic [WIDTH-1:0]          i,
  input  logic                      o_tready,
  output logic                      o_tvalid,
  output logic [WIDTH-1:0]          o_tdata,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  input  logic                      clr_overflow
`ifdef STRB_AXIS_FIFO_DROP_CNT_EN
  ,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
`endif
);

  localparam int ADDR_W = addr_w(DEPTH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("strb_axis_fifo: DEPTH must be a power of 2 and at least 2");
    end
    if (DROP_CNT_WIDTH < 1) begin : g_bad_cnt_width
      $error("strb_axis_fifo: DROP_CNT_WIDTH must be at least 1");
    end
  endgenerate

  logic              push;
  logic              pop;
  logic              drop;
  logic              overflow_r;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  flags_t            flags;
  logic [WIDTH-1:0]  mem [DEPTH];

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk     (clk),
    .sreset  (sreset),
    .strb    (i_strb),
    .tready  (o_tready),
    .push    (push),
    .pop     (pop),
    .wr_addr (wr_addr),
    .rd_addr (rd_addr),
    .level   (level),
    .full    (flags.full),
    .empty   (flags.empty)
  );

  assign flags.overflow = overflow_r;

  always_ff @(posedge clk) begin
    if (push) mem[wr_addr] <= i;
  end

  assign o_tvalid = !flags.empty;
  assign o_tdata  = mem[rd_addr];
  assign overflow = flags.overflow;

  // Reset-cycle strobes are neither stored nor counted as drops.
  assign drop = i_strb && flags.full && !pop && !sreset;

  always_ff @(posedge clk) begin
    if (sreset)            overflow_r <= 1'b0;
    else if (drop)         overflow_r <= 1'b1;
    else if (clr_overflow) overflow_r <= 1'b0;
  end

`ifdef STRB_AXIS_FIFO_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (sreset) begin
      drop_cnt <= '0;
    end else if (clr_overflow) begin
      drop_cnt <= drop ? {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1} : '0;
    end else if (drop && drop_cnt != {DROP_CNT_WIDTH{1'b1}}) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_strb_axis_fifo.sv
// tb_strb_axis_fifo: scoreboard bench for strb_axis_fifo (directed test plan plus random traffic).
`default_nettype none

module tb_strb_axis_fifo;

  localparam int WIDTH = 2;
  localparam int DEPTH = 4;
  localparam int DCW   = 16;

  logic             clk = 1'b0;
  logic             sreset;
  logic             i_strb;
  logic [WIDTH-1:0] din;
  logic             o_tready;
  logic             o_tvalid;
  logic [WIDTH-1:0] o_tdata;
  logic [2:0]       level;
  logic             overflow;
  logic             clr_overflow;
`ifdef STRB_AXIS_FIFO_DROP_CNT_EN
  logic [DCW-1:0]   drop_cnt;
`endif

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] q[$];
  logic             m_ovf = 1'b0;
  int               m_cnt = 0;

  always #5 clk = ~clk;

  strb_axis_fifo #(
    .WIDTH          (WIDTH),
    .DEPTH          (DEPTH),
    .DROP_CNT_WIDTH (DCW)
  ) dut (
    .clk          (clk),
    .sreset       (sreset),
    .i_strb       (i_strb),
    .i            (din),
    .o_tready     (o_tready),
    .o_tvalid     (o_tvalid),
    .o_tdata      (o_tdata),
    .level        (level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
`ifdef STRB_AXIS_FIFO_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, check outputs against the model, then advance the model.
  task automatic cycle(input logic s, input logic [WIDTH-1:0] d, input logic rdy,
                       input logic clr, input logic rst);
    logic m_pop, m_full, m_drop;
    i_strb = s; din = d; o_tready = rdy; clr_overflow = clr; sreset = rst;
    @(negedge clk);
    check("tvalid", {31'b0, o_tvalid}, {31'b0, q.size() != 0});
    check("level", {29'b0, level}, q.size());
    check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
`ifdef STRB_AXIS_FIFO_DROP_CNT_EN
    check("drop_cnt", {16'b0, drop_cnt}, m_cnt);
`endif
    if (q.size() != 0) check("tdata", {30'b0, o_tdata}, {30'b0, q[0]});
    m_pop  = (q.size() != 0) && rdy;
    m_full = (q.size() == DEPTH);
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_cnt = 0;
    end else begin
      m_drop = s && m_full && !m_pop;
      if (m_pop) void'(q.pop_front());
      if (s && !m_drop) q.push_back(d);
      if (m_drop)   m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (clr)                               m_cnt = m_drop ? 1 : 0;
      else if (m_drop && m_cnt != (1 << DCW) - 1) m_cnt = m_cnt + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, '0, rdy, 1'b0, 1'b0);
  endtask

  task automatic fill4();
    cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    sreset = 1'b1; i_strb = 1'b0; din = '0; o_tready = 1'b0; clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Single strobe, then one accepted beat.
    cycle(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    check("single_tdata", {30'b0, o_tdata}, 32'h2);
    idle(1'b1);
    idle(1'b0);
    check("single_empty", {29'b0, level}, 32'h0);

    // Fill, then drain in order.
    fill4();
    check("full_level", {29'b0, level}, 32'h4);
    repeat (4) idle(1'b1);
    idle(1'b0);

    // Drop while full, then clear.
    fill4();
    cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("drop_flag", {31'b0, overflow}, 32'h1);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    repeat (4) idle(1'b1);

    // Full with simultaneous pop and push: no drop.
    fill4();
    cycle(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    check("pp_level", {29'b0, level}, 32'h4);
    repeat (5) idle(1'b1);

    // Drop together with clear: set wins.
    fill4();
    cycle(1'b1, 2'd3, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    check("setwins", {31'b0, overflow}, 32'h1);
`ifdef STRB_AXIS_FIFO_DROP_CNT_EN
    check("setwins_cnt", {16'b0, drop_cnt}, 32'h1);
`endif
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);

    // Reset with stored entries and a concurrent strobe.
    cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    check("rst_tvalid", {31'b0, o_tvalid}, 32'h0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 2) != 0, 2'($urandom), $urandom_range(0, 2) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
    end
    repeat (6) idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
